level_frame_ctrl: RTL and testbench
===================================

# level_frame_ctrl

Frame controller between the UART receiver and the VGA bar renderer of the VU meter. It parses the received byte stream into framed level packets: a sync byte, CH_NO level bytes and an XOR checksum. Each valid frame is collected into a shadow bank and committed atomically to the display bank only during vertical blank, so a bar set never tears mid-frame. Malformed, stalled or overlapping frames are rejected and reported.

## Interface

- CH_NO, 16: number of level channels per frame.
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEVEL, 8'd200: clamp ceiling for stored levels (bar height).
- TIMEOUT, 20000: maximum idle clk cycles between bytes inside a frame.
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  reset; **synchronous, active-high**.
- byte_in  in  8  received byte; sampled only when byte_valid=1.
- byte_valid  in  1  one-cycle strobe, synchronous to clk, marking a new byte.
- fmt_err  in  1  UART framing error strobe; aborts the frame in progress.
- v_blank  in  1  level-high while the VGA is in vertical blanking.
- levels_out  out  8*CH_NO  committed display bank; channel k occupies bits [8k+7:8k].
- commit  out  1  one-cycle pulse in the cycle levels_out takes new values.
- chk_err  out  1  one-cycle pulse on checksum mismatch.
- tmo_err  out  1  one-cycle pulse on inter-byte timeout.
- drop_cnt  out  8  saturating count of bytes discarded while a frame is pending.
- busy  out  1  high in every state except IDLE.

## Operation

- States: IDLE, RECV, CHK, PEND.
- IDLE: on a byte equal to SYNC_BYTE, clear the running XOR and the channel index, then go to RECV. Any other byte is ignored and not counted.
- RECV: each byte is XORed into the running checksum. The byte, clamped to MAX_LEVEL (stored value = min(byte, MAX_LEVEL)), is written to shadow[idx] and idx increments. After byte CH_NO-1, go to CHK. A SYNC_BYTE value inside RECV is ordinary data.
- CHK: the next byte is compared with the running XOR of the raw, unclamped data bytes. On a match, go to PEND. On a mismatch, pulse chk_err and go to IDLE.
- PEND: wait for v_blank=1, then load levels_out from shadow, pulse commit and go to IDLE. Bytes arriving in PEND are discarded and increment drop_cnt, which saturates at 255.
- Timeout: in RECV and CHK, an idle counter clears on every byte_valid and increments otherwise. When it reaches TIMEOUT, pulse tmo_err and go to IDLE. PEND has no timeout.
- fmt_err in RECV or CHK: go to IDLE without an error pulse and discard the shadow contents. In IDLE or PEND it has no effect.
- levels_out changes only on commit.

## Timing

- Reset values: levels_out=0, commit=0, chk_err=0, tmo_err=0, drop_cnt=0, busy=0, state=IDLE.
- rst mid-frame or while pending clears everything above, including the committed bank, in the cycle after rst is sampled.
- A byte is consumed on the edge where byte_valid=1. The state change is visible the next cycle.
- Entering PEND with v_blank already high: commit occurs one cycle after PEND entry. Minimum latency from the checksum byte strobe to commit is 2 cycles.
- Simultaneous events:
  - byte_valid in the same cycle the counter hits TIMEOUT: the byte wins and the counter clears.
  - fmt_err together with byte_valid in RECV or CHK: the abort wins and the byte is discarded.
  - v_blank with byte_valid in PEND: commit happens and the byte is dropped (drop_cnt increments).
- After commit, IDLE accepts a sync byte in the very next cycle.
- chk_err, tmo_err and commit are mutually exclusive. Each is exactly 1 cycle wide.

## Test plan

- Reset, then A5, bytes 01..10 (16 bytes), checksum 10, with v_blank=1: commit pulse; levels_out channel0=01 … channel15=10; busy returns to 0.
- Same frame with checksum 11: chk_err pulse; levels_out unchanged (all 0); no commit.
- Frame with byte FF on channel 3 and a checksum computed on raw FF: commit; channel3 reads C8.
- Sync, 5 data bytes, then silence for TIMEOUT cycles: tmo_err pulse at exactly TIMEOUT idle cycles; state IDLE; a following good frame commits normally.
- Valid frame completes with v_blank=0, then 3 more bytes arrive: no commit and drop_cnt=3. Raise v_blank: commit 1 cycle later with the original frame's levels.
- fmt_err pulsed at the 8th data byte, then a full good frame: only the second frame commits; no error pulses. Assert rst mid-frame: all outputs return to 0.

Source files
------------

// File: rtl/level_frame_ctrl.sv
// Parses sync/level/checksum frames and commits them to the display bank during v_blank.
// Commit lands 2 cycles after the checksum byte at best; bytes arriving while a frame waits for v_blank are dropped and counted.
module level_frame_ctrl #(
  parameter int         CH_NO     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] MAX_LEVEL = 8'd200,
  parameter int         TIMEOUT   = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               fmt_err,
  input  logic               v_blank,
  output logic [8*CH_NO-1:0] levels_out,
  output logic               commit,
  output logic               chk_err,
  output logic               tmo_err,
  output logic [7:0]         drop_cnt,
  output logic               busy
);

  localparam int IW = (CH_NO > 1) ? $clog2(CH_NO) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHK, PEND} state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [TW-1:0]      idle_cnt;
  logic [7:0]         xor_acc;
  logic [8*CH_NO-1:0] shadow;
  logic [7:0]         clamped;
  logic               idle_hit;
  logic               last_ch;

  assign clamped  = (byte_in > MAX_LEVEL) ? MAX_LEVEL : byte_in;
  assign idle_hit = (idle_cnt == TW'(TIMEOUT - 1));
  assign last_ch  = (idx == IW'(CH_NO - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      idle_cnt   <= '0;
      xor_acc    <= '0;
      shadow     <= '0;
      levels_out <= '0;
      commit     <= 1'b0;
      chk_err    <= 1'b0;
      tmo_err    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      commit  <= 1'b0;
      chk_err <= 1'b0;
      tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_valid && byte_in == SYNC_BYTE) begin
            xor_acc  <= '0;
            idx      <= '0;
            idle_cnt <= '0;
            state    <= RECV;
          end
        end
        RECV, CHK: begin
          // An aborted frame must never reach the display bank.
          if (fmt_err) begin
            shadow <= '0;
            state  <= IDLE;
          end else if (byte_valid) begin
            idle_cnt <= '0;
            if (state == RECV) begin
              xor_acc                <= xor_acc ^ byte_in;
              shadow[8*idx +: 8]     <= clamped;
              idx                    <= idx + 1'b1;
              if (last_ch) state <= CHK;
            end else if (byte_in == xor_acc) begin
              state <= PEND;
            end else begin
              chk_err <= 1'b1;
              state   <= IDLE;
            end
          end else if (idle_hit) begin
            tmo_err <= 1'b1;
            state   <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        PEND: begin
          if (byte_valid && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
          if (v_blank) begin
            levels_out <= shadow;
            commit     <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_level_frame_ctrl.sv
// Bench for level_frame_ctrl: directed frames plus random frame traffic against a frame-level model.
module tb_level_frame_ctrl;

  localparam int         CH   = 16;
  localparam int         TMO  = 40;
  localparam int         LW   = 8 * CH;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] MAXL = 8'd200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          fmt_err = 1'b0;
  logic          v_blank = 1'b0;
  logic [LW-1:0] levels_out;
  logic          commit, chk_err, tmo_err, busy;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  level_frame_ctrl #(.CH_NO(CH), .SYNC_BYTE(SYNC), .MAX_LEVEL(MAXL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .fmt_err(fmt_err),
    .v_blank(v_blank), .levels_out(levels_out), .commit(commit), .chk_err(chk_err),
    .tmo_err(tmo_err), .drop_cnt(drop_cnt), .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Frame-level reference: raw bytes of the open frame, a pending bank and the visible bank.
  bit         m_in_frame = 0;
  bit         m_pending  = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_pend[CH];
  logic [7:0] m_bank[CH];
  int         m_idle = 0;
  int         m_drop = 0;
  bit         m_commit = 0, m_chk = 0, m_tmo = 0;

  initial foreach (m_bank[k]) m_bank[k] = '0;

  task automatic model_step(input bit bv, input logic [7:0] b, input bit fe, input bit vb, input bit r);
    logic [7:0] x;
    m_commit = 0; m_chk = 0; m_tmo = 0;
    if (r) begin
      m_in_frame = 0; m_pending = 0; m_drop = 0; m_idle = 0;
      m_q.delete();
      foreach (m_bank[k]) m_bank[k] = '0;
    end else if (m_pending) begin
      if (bv && m_drop < 255) m_drop++;
      if (vb) begin
        m_bank = m_pend; m_commit = 1; m_pending = 0;
      end
    end else if (m_in_frame) begin
      if (fe) m_in_frame = 0;
      else if (bv) begin
        m_idle = 0;
        if (m_q.size() < CH) m_q.push_back(b);
        else begin
          x = '0;
          foreach (m_q[i]) x ^= m_q[i];
          if (b == x) begin
            foreach (m_pend[k]) m_pend[k] = (m_q[k] > MAXL) ? MAXL : m_q[k];
            m_pending = 1;
          end else m_chk = 1;
          m_in_frame = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_tmo = 1; m_in_frame = 0; end
      end
    end else if (bv && b == SYNC) begin
      m_in_frame = 1; m_idle = 0; m_q.delete();
    end
  endtask

  task automatic cyc(input bit bv, input logic [7:0] b, input bit fe, input bit vb, input bit r);
    logic [LW-1:0] exp;
    @(negedge clk);
    byte_valid = bv; byte_in = b; fmt_err = fe; v_blank = vb; rst = r;
    @(posedge clk);
    model_step(bv, b, fe, vb, r);
    #1;
    foreach (m_bank[k]) exp[8*k +: 8] = m_bank[k];
    check("commit", LW'(commit), LW'(m_commit));
    check("chk_err", LW'(chk_err), LW'(m_chk));
    check("tmo_err", LW'(tmo_err), LW'(m_tmo));
    check("busy", LW'(busy), LW'(m_in_frame | m_pending));
    check("drop_cnt", LW'(drop_cnt), LW'(m_drop));
    check("levels_out", levels_out, exp);
  endtask

  task automatic sendb(input logic [7:0] b, input bit vb);
    cyc(1'b1, b, 1'b0, vb, 1'b0);
  endtask

  task automatic idle(input bit vb);
    cyc(1'b0, 8'h00, 1'b0, vb, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic bit rvb();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic rbyte(input logic [7:0] b);
    if ($urandom_range(0, 29) == 0) repeat (TMO + 2) idle(rvb());
    else repeat ($urandom_range(0, 2)) cyc(1'b0, 8'h00, ($urandom_range(0, 199) == 0), rvb(), 1'b0);
    cyc(1'b1, b, ($urandom_range(0, 99) == 0), rvb(), 1'b0);
  endtask

  task automatic rand_frame();
    logic [7:0] d;
    logic [7:0] x;
    if ($urandom_range(0, 4) == 0) cyc(1'b1, 8'($urandom), 1'b0, rvb(), 1'b0);
    rbyte(SYNC);
    x = '0;
    for (int i = 0; i < CH; i++) begin
      case ($urandom_range(0, 3))
        0:       d = SYNC;
        1:       d = 8'($urandom_range(201, 255));
        default: d = 8'($urandom);
      endcase
      x ^= d;
      rbyte(d);
    end
    if ($urandom_range(0, 4) == 0) x ^= 8'($urandom_range(1, 255));
    rbyte(x);
    repeat ($urandom_range(0, 3)) idle(rvb());
  endtask

  logic [LW-1:0] vexp;
  logic [7:0]    xs;

  initial begin
    // Reset values
    do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_levels", levels_out, '0);
    check("rst_busy", LW'(busy), '0);
    check("rst_drop", LW'(drop_cnt), '0);

    // Good frame 01..10, checksum 10, v_blank high
    sendb(SYNC, 1'b1);
    for (int i = 1; i <= CH; i++) sendb(8'(i), 1'b1);
    sendb(8'h10, 1'b1);
    check("t1_commit_not_yet", LW'(commit), '0);
    check("t1_pending_busy", LW'(busy), LW'(1));
    idle(1'b1);
    check("t1_commit", LW'(commit), LW'(1));
    for (int k = 0; k < CH; k++) vexp[8*k +: 8] = 8'(k + 1);
    check("t1_levels", levels_out, vexp);
    idle(1'b0);
    check("t1_commit_width", LW'(commit), '0);
    check("t1_busy_clear", LW'(busy), '0);

    // Bad checksum
    do_reset();
    sendb(SYNC, 1'b1);
    for (int i = 1; i <= CH; i++) sendb(8'(i), 1'b1);
    sendb(8'h11, 1'b1);
    check("t2_chk_err", LW'(chk_err), LW'(1));
    idle(1'b1);
    idle(1'b1);
    check("t2_levels_zero", levels_out, '0);

    // Clamp: raw FF on channel 3 takes part in the checksum
    sendb(SYNC, 1'b1);
    xs = '0;
    for (int i = 0; i < CH; i++) begin
      logic [7:0] v;
      v = (i == 3) ? 8'hFF : 8'(i + 1);
      xs ^= v;
      sendb(v, 1'b1);
    end
    sendb(xs, 1'b1);
    idle(1'b1);
    check("t3_commit", LW'(commit), LW'(1));
    check("t3_ch3_clamp", LW'(levels_out[31:24]), LW'(8'hC8));

    // Timeout after 5 data bytes
    sendb(SYNC, 1'b0);
    for (int i = 0; i < 5; i++) sendb(8'h33, 1'b0);
    repeat (TMO - 1) idle(1'b0);
    check("t4_no_tmo_early", LW'(tmo_err), '0);
    idle(1'b0);
    check("t4_tmo", LW'(tmo_err), LW'(1));
    check("t4_idle", LW'(busy), '0);
    sendb(SYNC, 1'b1);
    for (int i = 0; i < CH; i++) sendb(8'h05, 1'b1);
    sendb(8'h00, 1'b1);
    idle(1'b1);
    check("t4_recover_commit", LW'(commit), LW'(1));

    // Pending frame drops bytes until v_blank
    do_reset();
    sendb(SYNC, 1'b0);
    xs = '0;
    for (int i = 0; i < CH; i++) begin xs ^= 8'(8'h20 + i); sendb(8'(8'h20 + i), 1'b0); end
    sendb(xs, 1'b0);
    for (int i = 0; i < 3; i++) sendb(8'h77, 1'b0);
    idle(1'b0);
    check("t5_drop3", LW'(drop_cnt), LW'(3));
    check("t5_no_commit", LW'(commit), '0);
    idle(1'b1);
    check("t5_commit", LW'(commit), LW'(1));
    check("t5_ch0", LW'(levels_out[7:0]), LW'(8'h20));

    // fmt_err at the 8th data byte, then a good frame
    do_reset();
    sendb(SYNC, 1'b1);
    for (int i = 0; i < 7; i++) sendb(8'h44, 1'b1);
    cyc(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
    check("t6_abort_idle", LW'(busy), '0);
    sendb(SYNC, 1'b1);
    for (int i = 0; i < CH; i++) sendb(8'h09, 1'b1);
    sendb(8'h00, 1'b1);
    idle(1'b1);
    check("t6_commit", LW'(commit), LW'(1));
    check("t6_ch15", LW'(levels_out[LW-1 -: 8]), LW'(8'h09));

    // rst mid-frame
    sendb(SYNC, 1'b0);
    sendb(8'h12, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t7_levels_cleared", levels_out, '0);
    check("t7_busy_cleared", LW'(busy), '0);

    // Random frame traffic
    do_reset();
    for (int f = 0; f < 300; f++) rand_frame();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
